// File: rtl/dts_result_reader_if.sv
// Result stream from dts_result_reader: one DTS mark per beat over valid/ready.
interface dts_result_reader_if #(
  parameter int n_iWIDTH = 2,
  parameter int M_WIDTH  = 5
) ();
  logic                out_valid;
  logic                out_ready;
  logic [n_iWIDTH-1:0] out_block;
  logic [M_WIDTH-1:0]  out_mark;
  logic                out_last;

  modport master (output out_valid, out_block, out_mark, out_last, input out_ready);
  modport slave  (input out_valid, out_block, out_mark, out_last, output out_ready);
endinterface

// File: rtl/dts_result_reader.sv
// Snapshots a worker's packed rulers on done, validates the DTS, streams its marks.
// Optional DTS_RESULT_CHECK_EN builds the per-difference CHECK pass; otherwise check_ok just flags a capture.
module dts_result_reader #(
  parameter int n         = 3,
  parameter int k         = 3,
  parameter int M         = 19,
  parameter int n_iWIDTH  = 2,
  parameter int M_WIDTH   = 5,
  parameter int CNT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [n*(M+1)-1:0]   natRuler,
  input  logic                 done,
  dts_result_reader_if.master  res,
  output logic                 check_ok,
  output logic                 check_fail,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, CHECK, EMIT, HOLD} state_t;

  function automatic logic [CNT_WIDTH-1:0] popcnt(input logic [M:0] v);
    logic [CNT_WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i <= M; i++) c = c + CNT_WIDTH'(v[i]);
    return c;
  endfunction

  state_t              state;
  logic [n-1:0][M:0]   snap;
  logic [n-1:0][M:0]   capV;
  logic [n-1:0][M:0]   startVec;
  logic [n_iWIDTH-1:0] blk;
  logic [M:0]          work;
  logic                okQ;

  assign capV = natRuler;

  // Marks exclude bit 0, so a block counts as non-empty only on bits M..1.
  logic [n-1:0] snapNz, startNz;
  always_comb begin
    for (int i = 0; i < n; i++) begin
      snapNz[i]  = |snap[i][M:1];
      startNz[i] = |startVec[i][M:1];
    end
  end

  logic                startHit, nextHit;
  logic [n_iWIDTH-1:0] startBlk, nextBlk;
  always_comb begin
    startHit = 1'b0;
    startBlk = '0;
    nextHit  = 1'b0;
    nextBlk  = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (startNz[i]) begin
        startHit = 1'b1;
        startBlk = n_iWIDTH'(i);
      end
      if (snapNz[i] && (i > int'(blk))) begin
        nextHit = 1'b1;
        nextBlk = n_iWIDTH'(i);
      end
    end
  end

  logic [M:0] startWork;
  assign startWork = {startVec[startBlk][M:1], 1'b0};

  // Lowest set bit is the current mark; clearing it is work & (work-1).
  logic [M:0]         workClr;
  logic [M_WIDTH-1:0] markIdx;
  logic               oneLeft;
  assign workClr = work & (work - (M+1)'(1));
  assign oneLeft = popcnt(work) == CNT_WIDTH'(1);
  always_comb begin
    markIdx = '0;
    for (int i = M; i >= 1; i--) if (work[i]) markIdx = M_WIDTH'(i);
  end

  logic emitting;
  assign emitting      = (state == EMIT);
  assign res.out_valid = emitting;
  assign res.out_block = emitting ? blk : '0;
  assign res.out_mark  = emitting ? markIdx : '0;
  assign res.out_last  = emitting && oneLeft && !nextHit;
  assign busy          = (state != IDLE);
  assign check_ok      = okQ;

`ifdef DTS_RESULT_CHECK_EN
  logic [M:0]         mask;
  logic [M_WIDTH-1:0] s;
  logic               fail, failQ;
  logic [M:0]         w, d;
  logic               cycFail, failAll;

  assign startVec   = snap;
  assign check_fail = failQ;

  // d has one bit per pair of marks in this block whose difference is s.
  always_comb begin
    w       = snap[blk];
    d       = w & (w >> s);
    cycFail = (popcnt(d) > CNT_WIDTH'(1)) || ((d != '0) && mask[s]);
    if (s == M_WIDTH'(1))
      cycFail = cycFail || !w[0] || (popcnt(w) != CNT_WIDTH'(k + 1));
    failAll = fail || cycFail;
  end
`else
  assign startVec   = capV;
  assign check_fail = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      snap  <= '0;
      blk   <= '0;
      work  <= '0;
      okQ   <= 1'b0;
`ifdef DTS_RESULT_CHECK_EN
      mask  <= '0;
      s     <= '0;
      fail  <= 1'b0;
      failQ <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (done) begin
          snap <= natRuler;
          blk  <= '0;
`ifdef DTS_RESULT_CHECK_EN
          okQ   <= 1'b0;
          failQ <= 1'b0;
          mask  <= '0;
          s     <= M_WIDTH'(1);
          fail  <= 1'b0;
          state <= CHECK;
`else
          okQ <= 1'b1;
          if (startHit) begin
            state <= EMIT;
            blk   <= startBlk;
            work  <= startWork;
          end else begin
            state <= HOLD;
          end
`endif
        end
`ifdef DTS_RESULT_CHECK_EN
        CHECK: begin
          if (d != '0) mask[s] <= 1'b1;
          fail <= failAll;
          if (s == M_WIDTH'(M)) begin
            s <= M_WIDTH'(1);
            if (blk == n_iWIDTH'(n - 1)) begin
              okQ   <= !failAll;
              failQ <= failAll;
              // Empty leading blocks are skipped; an all-empty set goes straight to HOLD.
              if (startHit) begin
                state <= EMIT;
                blk   <= startBlk;
                work  <= startWork;
              end else begin
                state <= HOLD;
              end
            end else begin
              blk <= blk + n_iWIDTH'(1);
            end
          end else begin
            s <= s + M_WIDTH'(1);
          end
        end
`endif
        EMIT: if (res.out_ready) begin
          if (workClr != '0) begin
            work <= workClr;
          end else if (nextHit) begin
            blk  <= nextBlk;
            work <= {snap[nextBlk][M:1], 1'b0};
          end else begin
            work  <= '0;
            state <= HOLD;
          end
        end
        HOLD: if (!done) begin
          state <= IDLE;
          okQ   <= 1'b0;
`ifdef DTS_RESULT_CHECK_EN
          failQ <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dts_result_reader.sv
// Directed table-driven bench for dts_result_reader at n=2, k=2, M=9.
module tb_dts_result_reader;
  localparam int N = 2, K = 2, MM = 9, NW = 1, MW = 4, CW = 4;
`ifdef DTS_RESULT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int LAT = CHK ? 1 + N * MM : 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N*(MM+1)-1:0] natRuler;
  logic              done;
  logic              check_ok, check_fail, busy;
  int                checks = 0, errors = 0;

  dts_result_reader_if #(.n_iWIDTH(NW), .M_WIDTH(MW)) res ();

  dts_result_reader #(.n(N), .k(K), .M(MM), .n_iWIDTH(NW), .M_WIDTH(MW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .natRuler(natRuler), .done(done), .res(res),
    .check_ok(check_ok), .check_fail(check_fail), .busy(busy)
  );

  always #5 clk = ~clk;

  // Beat encoding: {block, mark, last}
  typedef struct {
    logic [19:0]      ruler;
    bit               ok;
    bit               fail;
    int               nb;
    logic [3:0][5:0]  beat;
  } vec_t;

  vec_t vecs [5];

  function automatic logic [5:0] bt(input int b, input int m, input bit l);
    return {1'(b), 4'(m), l};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] cur();
    return {res.out_block, res.out_mark, res.out_last};
  endfunction

  task automatic runVec(input int id, input bit stall);
    vec_t v;
    int cnt, bi, pc;
    logic [5:0] held;
    bit heldV, sawValid;
    logic [3:0] pat;
    v   = vecs[id];
    pat = 4'b1001;
    @(negedge clk);
    natRuler = v.ruler; done = 1'b1; res.out_ready = 1'b1;
    @(posedge clk); #1;
    natRuler = ~v.ruler;   // post-capture changes must be ignored
    cnt = 1;
    sawValid = res.out_valid;
    if (v.nb == 0) begin
      repeat (LAT + 3) begin
        @(posedge clk); #1;
        if (res.out_valid) sawValid = 1'b1;
      end
      check($sformatf("v%0d noBeats", id), 32'(sawValid), 0);
    end else begin
      while (!res.out_valid && cnt < 200) begin
        @(posedge clk); #1; cnt++;
      end
      check($sformatf("v%0d latency", id), cnt, LAT);
      bi = 0; pc = 0; heldV = 1'b0;
      while (bi < v.nb && pc < 60) begin
        @(negedge clk);
        res.out_ready = stall ? pat[pc % 4] : 1'b1;
        pc++;
        check($sformatf("v%0d noBubble", id), 32'(res.out_valid), 1);
        if (heldV) check($sformatf("v%0d stable", id), 32'(cur()), 32'(held));
        heldV = 1'b0;
        if (res.out_valid && res.out_ready) begin
          check($sformatf("v%0d beat%0d", id, bi), 32'(cur()), 32'(v.beat[bi]));
          bi++;
        end else if (res.out_valid) begin
          held = cur(); heldV = 1'b1;
        end
      end
      check($sformatf("v%0d beatCount", id), bi, v.nb);
      @(negedge clk);
      check($sformatf("v%0d validAfterLast", id), 32'(res.out_valid), 0);
    end
    check($sformatf("v%0d check_ok", id), 32'(check_ok), CHK ? 32'(v.ok) : 1);
    check($sformatf("v%0d check_fail", id), 32'(check_fail), CHK ? 32'(v.fail) : 0);
    // done still high: no recapture, stays in HOLD
    repeat (4) @(negedge clk);
    check($sformatf("v%0d holdBusy", id), 32'(busy), 1);
    check($sformatf("v%0d holdValid", id), 32'(res.out_valid), 0);
    done = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d idleBusy", id), 32'(busy), 0);
    check($sformatf("v%0d idleOk", id), 32'(check_ok), 0);
  endtask

  initial begin
    vecs[0] = '{20'h8440B, 1'b1, 1'b0, 4, {bt(1,9,1), bt(1,4,0), bt(0,3,0), bt(0,1,0)}};
    vecs[1] = '{20'h1140B, 1'b0, 1'b1, 4, {bt(1,6,1), bt(1,2,0), bt(0,3,0), bt(0,1,0)}};
    vecs[2] = '{20'h0440B, 1'b0, 1'b1, 3, {6'd0,      bt(1,4,1), bt(0,3,0), bt(0,1,0)}};
    vecs[3] = '{20'h00401, 1'b0, 1'b1, 0, {6'd0, 6'd0, 6'd0, 6'd0}};
    vecs[4] = '{20'h22400, 1'b0, 1'b1, 2, {6'd0, 6'd0, bt(1,7,1), bt(1,3,0)}};

    reset_n = 1'b0; done = 1'b0; natRuler = '0; res.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst valid", 32'(res.out_valid), 0);
    check("rst busy", 32'(busy), 0);
    check("rst ok", 32'(check_ok), 0);
    check("rst fail", 32'(check_fail), 0);
    check("rst data", 32'(cur()), 0);
    reset_n = 1'b1;

    for (int i = 0; i < 5; i++) runVec(i, 1'b0);
    runVec(0, 1'b1);
    runVec(1, 1'b1);

    // Asynchronous reset mid-EMIT
    @(negedge clk);
    natRuler = vecs[0].ruler; done = 1'b1; res.out_ready = 1'b1;
    repeat (LAT + 1) @(posedge clk);
    #1;
    check("midEmit valid", 32'(res.out_valid), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("asyncRst valid", 32'(res.out_valid), 0);
    check("asyncRst busy", 32'(busy), 0);
    check("asyncRst ok", 32'(check_ok), 0);
    done = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("postRst busy", 32'(busy), 0);
    check("postRst ok", 32'(check_ok), 0);
    check("postRst valid", 32'(res.out_valid), 0);
    runVec(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
